apb_slave_mux_if: RTL and testbench

Parametrised APB slave interface that terminates one APB requester port and fans each transfer out to one of NUM_CH downstream register blocks. Selection is by address window. Adds PSTRB/PPROT pass-through, decode errors, per-transfer timeout, protocol-violation checking and a saturating error counter. Sits between the APB interconnect and a group of peripheral register banks.

---
 rtl/apb_slave_mux_if_if.sv | 55 +++++
 rtl/apb_slave_mux_if.sv | 193 +++++++++++++++++++
 tb/tb_apb_slave_mux_if.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mux_if_if.sv
// Bus bundle for apb_slave_mux_if: the upstream APB requester signals, the
// fan-out towards the downstream register blocks and the error-count side band.
interface apb_slave_mux_if_if #(
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned CH_ADDR_BITS   = 12
);
   localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;

   // upstream APB
   logic                          apb_psel_in;
   logic                          apb_penable_in;
   logic                          apb_write_in;
   logic [APB_ADDR_WIDTH-1:0]     apb_addr_in;
   logic [APB_DATA_WIDTH-1:0]     apb_wdata_in;
   logic [STRB_W-1:0]             apb_strb_in;
   logic [2:0]                    apb_prot_in;
   logic [APB_DATA_WIDTH-1:0]     apb_rdata_out;
   logic                          apb_ready_out;
   logic                          apb_slverr_out;

   // downstream channels
   logic [NUM_CH-1:0]             other_sel_out;
   logic [CH_ADDR_BITS-1:0]       other_addr_out;
   logic                          other_write_out;
   logic [APB_DATA_WIDTH-1:0]     other_wdata_out;
   logic [STRB_W-1:0]             other_strb_out;
   logic [2:0]                    other_prot_out;
   logic [NUM_CH*APB_DATA_WIDTH-1:0] other_rdata_in;
   logic [NUM_CH-1:0]             other_ready_in;
   logic [NUM_CH-1:0]             other_error_in;

   // error counter side band
   logic                          err_clr_in;
   logic [7:0]                    err_count_out;

   modport slave (
      input  apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in,
             apb_wdata_in, apb_strb_in, apb_prot_in,
             other_rdata_in, other_ready_in, other_error_in, err_clr_in,
      output apb_rdata_out, apb_ready_out, apb_slverr_out,
             other_sel_out, other_addr_out, other_write_out, other_wdata_out,
             other_strb_out, other_prot_out, err_count_out
   );

   modport master (
      output apb_psel_in, apb_penable_in, apb_write_in, apb_addr_in,
             apb_wdata_in, apb_strb_in, apb_prot_in,
             other_rdata_in, other_ready_in, other_error_in, err_clr_in,
      input  apb_rdata_out, apb_ready_out, apb_slverr_out,
             other_sel_out, other_addr_out, other_write_out, other_wdata_out,
             other_strb_out, other_prot_out, err_count_out
   );
endinterface

// File: rtl/apb_slave_mux_if.sv
// APB slave that terminates one requester port and forwards each transfer to
// one of NUM_CH register blocks chosen by address window. Detects decode
// misses, downstream timeouts and mid-transfer protocol violations, answering
// all of them with PSLVERR, and keeps a saturating count of error responses.
module apb_slave_mux_if #(
   parameter int unsigned              APB_DATA_WIDTH = 32,
   parameter int unsigned              APB_ADDR_WIDTH = 32,
   parameter int unsigned              NUM_CH         = 4,
   parameter int unsigned              CH_ADDR_BITS   = 12,
   parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int unsigned              TIMEOUT_CYCLE  = 16
) (
   input logic                apb_clk_in,
   input logic                apb_rst_in,
   apb_slave_mux_if_if.slave  bus
);
   localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLE);
   // one bit wider than the address so NUM_CH windows never overflow
   localparam logic [APB_ADDR_WIDTH:0] SPAN =
      (APB_ADDR_WIDTH+1)'(NUM_CH) << CH_ADDR_BITS;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                     state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [CH_ADDR_BITS-1:0]    off_q, off_d;
   logic                       write_q, write_d;
   logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [STRB_W-1:0]          strb_q, strb_d;
   logic [2:0]                 prot_q, prot_d;
   logic [CH_W-1:0]            ch_q, ch_d;
   logic [NUM_CH-1:0]          sel_q, sel_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [APB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                       ready_q, ready_d;
   logic                       slverr_q, slverr_d;
   logic [7:0]                 errcnt_q, errcnt_d;

   logic [APB_ADDR_WIDTH-1:0]  offset;
   logic                       hit;
   logic [CH_W-1:0]            ch_dec;
   logic                       violation;
   logic                       ch_ready;
   logic                       ch_error;
   logic [APB_DATA_WIDTH-1:0]  ch_rdata;

   // Address decode of the live bus plus the latched-vs-live protocol check.
   always_comb begin
      offset    = bus.apb_addr_in - BASE_ADDR;
      hit       = (bus.apb_addr_in >= BASE_ADDR) && ({1'b0, offset} < SPAN);
      ch_dec    = offset[CH_ADDR_BITS +: CH_W];
      violation = !bus.apb_penable_in
               || (bus.apb_addr_in  != paddr_q)
               || (bus.apb_write_in != write_q)
               || (bus.apb_prot_in  != prot_q)
               || (bus.apb_strb_in  != strb_q)
               || (write_q && (bus.apb_wdata_in != wdata_q));
      ch_ready  = bus.other_ready_in[ch_q];
      ch_error  = bus.other_error_in[ch_q];
      ch_rdata  = bus.other_rdata_in[int'(ch_q)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
   end

   // Next-state and registered-output logic of the IDLE/ACCESS/RESP machine.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d  = state_q;
      paddr_d  = paddr_q;
      off_d    = off_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      prot_d   = prot_q;
      ch_d     = ch_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      rdata_d  = '0;
      ready_d  = 1'b0;
      slverr_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.apb_psel_in && !bus.apb_penable_in) begin
               paddr_d = bus.apb_addr_in;
               off_d   = offset[CH_ADDR_BITS-1:0];
               write_d = bus.apb_write_in;
               wdata_d = bus.apb_wdata_in;
               strb_d  = bus.apb_write_in ? bus.apb_strb_in : '0;
               prot_d  = bus.apb_prot_in;
               ch_d    = ch_dec;
               cnt_d   = '0;
               if (hit) begin
                  sel_d   = NUM_CH'(1) << ch_dec;
                  state_d = ACCESS;
               end else begin
                  ready_d  = 1'b1;
                  slverr_d = 1'b1;
                  state_d  = RESP;
               end
            end
         end

         ACCESS: begin
            if (!bus.apb_psel_in) begin
               // requester walked away: drop the channel silently
               sel_d   = '0;
               state_d = IDLE;
            end else if (violation) begin
               sel_d    = '0;
               ready_d  = 1'b1;
               slverr_d = 1'b1;
               state_d  = RESP;
            end else if (ch_ready) begin
               sel_d    = '0;
               ready_d  = 1'b1;
               slverr_d = ch_error;
               rdata_d  = write_q ? '0 : ch_rdata;
               state_d  = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLE - 1)) begin
               sel_d    = '0;
               ready_d  = 1'b1;
               slverr_d = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // Saturating error counter; a clear wins over a same-cycle increment.
   always_comb begin
      errcnt_d = errcnt_q;
      if (bus.err_clr_in) begin
         errcnt_d = '0;
      end else if ((state_q == RESP) && slverr_q && (errcnt_q != 8'hFF)) begin
         errcnt_d = errcnt_q + 8'd1;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge apb_clk_in) begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      if (apb_rst_in) begin
         // NOTE: latched datapath registers are reset too, since they drive outputs that read 0 out of reset.
         state_q  <= IDLE;
         paddr_q  <= '0;
         off_q    <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         prot_q   <= '0;
         ch_q     <= '0;
         sel_q    <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         slverr_q <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         off_q    <= off_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         prot_q   <= prot_d;
         ch_q     <= ch_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         slverr_q <= slverr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign bus.apb_rdata_out   = rdata_q;
   assign bus.apb_ready_out   = ready_q;
   assign bus.apb_slverr_out  = slverr_q;
   assign bus.other_sel_out   = sel_q;
   assign bus.other_addr_out  = off_q;
   assign bus.other_write_out = write_q;
   assign bus.other_wdata_out = wdata_q;
   assign bus.other_strb_out  = strb_q;
   assign bus.other_prot_out  = prot_q;
   assign bus.err_count_out   = errcnt_q;
endmodule

// File: tb/tb_apb_slave_mux_if.sv
// Self-checking bench for apb_slave_mux_if: directed vector table, random
// transfers against a transfer-level reference model, and hand-written
// sequences for protocol violation, abandon, reset and counter saturation.
module tb_apb_slave_mux_if;
   localparam int          DW      = 32;
   localparam int          AW      = 32;
   localparam int          NUM_CH  = 4;
   localparam int          CH_BITS = 12;
   localparam int          TIMEOUT = 16;
   localparam logic [31:0] BASE    = 32'h1000_0000;
   localparam longint      WIN     = 64'd4096;
   localparam int          BUDGET  = TIMEOUT + 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   model_cnt = 0;

   always #5 clk = ~clk;

   apb_slave_mux_if_if #(
      .APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW),
      .NUM_CH(NUM_CH), .CH_ADDR_BITS(CH_BITS)
   ) bus ();

   apb_slave_mux_if #(
      .APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .NUM_CH(NUM_CH),
      .CH_ADDR_BITS(CH_BITS), .BASE_ADDR(BASE), .TIMEOUT_CYCLE(TIMEOUT)
   ) dut (
      .apb_clk_in(clk),
      .apb_rst_in(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          w;        // downstream wait cycles before ready
      bit          err;
      logic [31:0] rd;
      int          exp_lat;  // cycles from setup to apb_ready_out
      bit          exp_slv;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void bump_err();
      if (model_cnt < 255) model_cnt++;
   endfunction

   // Transfer-level reference: outcome from the address map and downstream latency.
   function automatic void model(input logic [31:0] addr, input bit wr, input int w,
                                 input bit err, input logic [31:0] rd,
                                 output int lat, output bit slv, output logic [31:0] rdat);
      longint off;
      off = longint'(addr) - longint'(BASE);
      if (off < 0 || off >= NUM_CH * WIN) begin
         lat = 1; slv = 1'b1; rdat = '0;
      end else if (w < TIMEOUT) begin
         lat = w + 2; slv = err; rdat = wr ? 32'h0 : rd;
      end else begin
         lat = TIMEOUT + 1; slv = 1'b1; rdat = '0;
      end
   endfunction

   // Downstream drive: chosen channel is deterministic, all others random noise.
   task automatic drive_ds(input bit hit, input int ch, input bit rdy, input bit err,
                           input logic [31:0] rd);
      logic [NUM_CH-1:0] r, e;
      r = NUM_CH'($urandom);
      e = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) bus.other_rdata_in[c*DW +: DW] = $urandom;
      if (hit) begin
         r[ch] = rdy;
         e[ch] = err;
         bus.other_rdata_in[ch*DW +: DW] = rd;
      end
      bus.other_ready_in = r;
      bus.other_error_in = e;
   endtask

   task automatic setup(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot);
      bus.apb_psel_in    = 1'b1;
      bus.apb_penable_in = 1'b0;
      bus.apb_addr_in    = addr;
      bus.apb_write_in   = wr;
      bus.apb_wdata_in   = wdata;
      bus.apb_strb_in    = strb;
      bus.apb_prot_in    = prot;
   endtask

   task automatic go_idle();
      bus.apb_psel_in    = 1'b0;
      bus.apb_penable_in = 1'b0;
      drive_ds(1'b0, 0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"},  bus.apb_ready_out, 0);
      check({tag, "_slverr"}, bus.apb_slverr_out, 0);
      check({tag, "_rdata"},  bus.apb_rdata_out, 0);
      check({tag, "_sel"},    bus.other_sel_out, 0);
      check({tag, "_addr"},   bus.other_addr_out, 0);
      check({tag, "_latched"}, {bus.other_write_out, bus.other_strb_out,
                                bus.other_prot_out, bus.other_wdata_out}, 0);
      check({tag, "_errcnt"}, bus.err_count_out, 0);
   endtask

   // One full APB transfer; entered and left at posedge+1.
   task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] strb_in, input logic [2:0] prot, input int w,
                          input bit err, input logic [31:0] rd, input int exp_lat,
                          input bit exp_slv, input logic [31:0] exp_rdata);
      longint            off;
      bit                hit;
      int                ch;
      logic [3:0]        strb;
      logic [NUM_CH-1:0] exp_sel;
      logic [39:0]       exp_bundle;
      int                lat_seen;
      off  = longint'(addr) - longint'(BASE);
      hit  = (off >= 0) && (off < NUM_CH * WIN);
      ch   = hit ? int'(off / WIN) : 0;
      strb = wr ? strb_in : 4'h0;
      exp_sel    = hit ? (NUM_CH'(1) << ch) : '0;
      exp_bundle = {wr, strb, prot, wdata};
      lat_seen   = BUDGET + 1;

      setup(addr, wr, wdata, strb, prot);
      drive_ds(hit, ch, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("idle_ready", bus.apb_ready_out, 0);
      check("err_count", bus.err_count_out, model_cnt);
      tick();
      for (int n = 1; n <= BUDGET; n++) begin
         bus.apb_penable_in = 1'b1;
         drive_ds(hit, ch, (n - 1) == w, err, rd);
         @(negedge clk);
         if (bus.apb_ready_out) begin
            lat_seen = n;
            check("resp_slverr", bus.apb_slverr_out, exp_slv);
            check("resp_rdata", bus.apb_rdata_out, exp_rdata);
            check("resp_sel_off", bus.other_sel_out, 0);
            check("resp_hold", {bus.other_write_out, bus.other_strb_out,
                                bus.other_prot_out, bus.other_wdata_out}, exp_bundle);
            check("resp_addr", bus.other_addr_out, off[CH_BITS-1:0]);
            tick();
            break;
         end
         check("access_sel", bus.other_sel_out, exp_sel);
         check("access_latched", {bus.other_write_out, bus.other_strb_out,
                                  bus.other_prot_out, bus.other_wdata_out}, exp_bundle);
         tick();
      end
      check("latency", lat_seen, exp_lat);
      if (exp_slv) bump_err();
      go_idle();
   endtask

   // Change one latched field in the second ACCESS cycle; selected ready is
   // asserted in that same cycle and must lose to the violation.
   task automatic violate(input int kind);
      logic [31:0] addr = BASE + 32'h1008;
      setup(addr, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b010);
      drive_ds(1'b1, 1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("viol_idle", bus.apb_ready_out, 0);
      tick();
      bus.apb_penable_in = 1'b1;
      drive_ds(1'b1, 1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("viol_wait", bus.apb_ready_out, 0);
      check("viol_sel", bus.other_sel_out, 4'b0010);
      tick();
      case (kind)
         0: bus.apb_addr_in    = addr ^ 32'h4;
         1: bus.apb_wdata_in   = 32'hCAFE_F00C;
         2: bus.apb_penable_in = 1'b0;
         3: bus.apb_prot_in    = 3'b011;
         4: bus.apb_strb_in    = 4'hB;
         default: bus.apb_write_in = 1'b0;
      endcase
      drive_ds(1'b1, 1, 1'b1, 1'b0, 32'h5555_5555);
      @(negedge clk);
      check("viol_detect_cycle", bus.apb_ready_out, 0);
      tick();
      drive_ds(1'b1, 1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("viol_ready", bus.apb_ready_out, 1);
      check("viol_slverr", bus.apb_slverr_out, 1);
      check("viol_rdata", bus.apb_rdata_out, 0);
      check("viol_sel_off", bus.other_sel_out, 0);
      bump_err();
      tick();
      go_idle();
   endtask

   // Decode miss as a bare two-cycle transfer, no checks.
   task automatic quick_miss(input bit clr_in_resp);
      setup(BASE + 32'h4000, 1'b0, 32'h0, 4'h0, 3'b000);
      tick();
      bus.apb_penable_in = 1'b1;
      bus.err_clr_in     = clr_in_resp;
      tick();
      bus.err_clr_in = 1'b0;
      go_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[9];
      logic [31:0] a, wd, rd;
      bit          wr, er;
      int          w, lat;
      bit          slv;
      logic [31:0] rdat;

      vecs[0] = '{BASE + 32'h2010, 1'b0, 32'h0,        4'h0, 3'b000, 0,   1'b0, 32'hDEAD_BEEF, 2,  1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{BASE + 32'h0000, 1'b1, 32'h1234_5678, 4'hF, 3'b001, 3,   1'b0, 32'h9999_9999, 5,  1'b0, 32'h0};
      vecs[2] = '{BASE + 32'h4000, 1'b0, 32'h0,        4'h0, 3'b000, 0,   1'b0, 32'h0,        1,  1'b1, 32'h0};
      vecs[3] = '{BASE + 32'h1100, 1'b0, 32'h0,        4'h0, 3'b100, 100, 1'b0, 32'h7777_7777, 17, 1'b1, 32'h0};
      vecs[4] = '{BASE + 32'h3FFC, 1'b0, 32'h0,        4'h0, 3'b010, 15,  1'b0, 32'hA5A5_A5A5, 17, 1'b0, 32'hA5A5_A5A5};
      vecs[5] = '{BASE + 32'h1004, 1'b1, 32'h0BAD_0BAD, 4'h6, 3'b111, 1,   1'b1, 32'h3333_3333, 3,  1'b1, 32'h0};
      vecs[6] = '{BASE + 32'h0FF0, 1'b0, 32'h0,        4'h0, 3'b000, 0,   1'b1, 32'h1111_2222, 2,  1'b1, 32'h1111_2222};
      vecs[7] = '{32'h0FFF_FFFC,   1'b1, 32'hFFFF_0000, 4'hC, 3'b000, 0,   1'b0, 32'h0,        1,  1'b1, 32'h0};
      vecs[8] = '{BASE + 32'h3000, 1'b1, 32'h5A5A_5A5A, 4'h1, 3'b101, 16,  1'b0, 32'h0,        17, 1'b1, 32'h0};

      bus.err_clr_in = 1'b0;
      setup(32'h0, 1'b0, 32'h0, 4'h0, 3'b000);
      go_idle();
      repeat (3) tick();
      @(negedge clk);
      check_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // directed vector table
      foreach (vecs[i]) begin
         do_xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                 vecs[i].w, vecs[i].err, vecs[i].rd,
                 vecs[i].exp_lat, vecs[i].exp_slv, vecs[i].exp_rdata);
      end

      // random transfers against the reference model
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 4) == 0)
            a = ($urandom_range(0, 1) == 1) ? BASE - 32'($urandom_range(1, 64))
                                            : BASE + 32'h4000 + 32'($urandom_range(0, 4095));
         else
            a = BASE + 32'($urandom_range(0, NUM_CH - 1)) * 32'd4096 + 32'($urandom_range(0, 4095));
         wr = 1'($urandom);
         wd = $urandom;
         rd = $urandom;
         er = ($urandom_range(0, 3) == 0);
         w  = $urandom_range(0, 18);
         model(a, wr, w, er, rd, lat, slv, rdat);
         do_xfer(a, wr, wd, 4'($urandom), 3'($urandom), w, er, rd, lat, slv, rdat);
         if ($urandom_range(0, 1) == 1) tick();
      end

      // protocol violations
      for (int k = 0; k < 6; k++) violate(k);

      // psel dropped mid-ACCESS while the channel signals ready: no response
      setup(BASE + 32'h2020, 1'b0, 32'h0, 4'h0, 3'b000);
      drive_ds(1'b1, 2, 1'b0, 1'b0, 32'h0);
      tick();
      bus.apb_penable_in = 1'b1;
      @(negedge clk);
      check("abandon_sel", bus.other_sel_out, 4'b0100);
      tick();
      bus.apb_psel_in    = 1'b0;
      bus.apb_penable_in = 1'b0;
      drive_ds(1'b1, 2, 1'b1, 1'b1, 32'h4444_4444);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abandon_no_ready", bus.apb_ready_out, 0);
         if (c == 1) check("abandon_sel_off", bus.other_sel_out, 0);
         tick();
      end
      go_idle();
      do_xfer(vecs[0].addr, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hDEAD_BEEF,
              2, 1'b0, 32'hDEAD_BEEF);

      // reset asserted mid-ACCESS
      setup(BASE + 32'h3ABC, 1'b1, 32'h8765_4321, 4'hF, 3'b111);
      drive_ds(1'b1, 3, 1'b0, 1'b0, 32'h0);
      tick();
      bus.apb_penable_in = 1'b1;
      @(negedge clk);
      check("rst_pre_sel", bus.other_sel_out, 4'b1000);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_zero("mid_reset");
      model_cnt = 0;
      tick();
      bus.apb_psel_in = 1'b0;
      @(negedge clk);
      check("post_reset_no_ready", bus.apb_ready_out, 0);
      tick();
      go_idle();

      // counter saturation and clear priority
      bus.err_clr_in = 1'b1;
      tick();
      bus.err_clr_in = 1'b0;
      @(negedge clk);
      check("clr_count", bus.err_count_out, 0);
      tick();
      for (int e = 0; e < 255; e++) quick_miss(1'b0);
      @(negedge clk);
      check("count_255", bus.err_count_out, 255);
      tick();
      quick_miss(1'b0);
      @(negedge clk);
      check("count_sat_256", bus.err_count_out, 255);
      tick();
      setup(BASE + 32'h4000, 1'b0, 32'h0, 4'h0, 3'b000);
      tick();
      bus.apb_penable_in = 1'b1;
      bus.err_clr_in     = 1'b1;
      @(negedge clk);
      check("clr_err_ready", bus.apb_ready_out, 1);
      check("clr_err_slverr", bus.apb_slverr_out, 1);
      tick();
      bus.err_clr_in = 1'b0;
      go_idle();
      @(negedge clk);
      check("clr_beats_inc", bus.err_count_out, 0);
      model_cnt = 0;
      tick();

      // normal transfer after everything
      do_xfer(BASE + 32'h1FF8, 1'b1, 32'hFEED_FACE, 4'hA, 3'b011, 2, 1'b0, 32'h0,
              4, 1'b0, 32'h0);
      @(negedge clk);
      check("final_err_count", bus.err_count_out, model_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
